// File: rtl/regfile_wb_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_if
// Bundles the writeback arbiter's request streams and register-file write port.
//   ALU stream : alu_valid, alu_rd[4:0], alu_data[DATA_W-1:0] (always accepted)
//   Slow stream: mem_valid, mem_rd[4:0], mem_data[DATA_W-1:0], mem_ready
//   Write port : reg_write, w_reg[4:0], w_data[DATA_W-1:0]
//   Status     : pend_mask[31:0], fifo_count[$clog2(DEPTH):0]
// master = producer side (pipeline/testbench), slave = the arbiter.
// -----------------------------------------------------------------------------
interface regfile_wb_if #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
);
  logic                     alu_valid;
  logic [4:0]               alu_rd;
  logic [DATA_W-1:0]        alu_data;
  logic                     mem_valid;
  logic                     mem_ready;
  logic [4:0]               mem_rd;
  logic [DATA_W-1:0]        mem_data;
  logic                     reg_write;
  logic [4:0]               w_reg;
  logic [DATA_W-1:0]        w_data;
  logic [31:0]              pend_mask;
  logic [$clog2(DEPTH):0]   fifo_count;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  mem_ready, reg_write, w_reg, w_data, pend_mask, fifo_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output mem_ready, reg_write, w_reg, w_data, pend_mask, fifo_count
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Merges a single-cycle ALU writeback stream and a long-latency slow writeback
// stream into one registered register-file write per cycle. The slow stream is
// buffered in a DEPTH-entry FIFO; the ALU always wins arbitration. An ALU write
// kills any older buffered write to the same register so the ALU value stays
// the newest. Writes to x0 are dropped.
//
// Ports:
//   clk          clock, all state on posedge
//   reset        asynchronous, active-high
//   wb           regfile_wb_if.slave (request streams, write port, status)
//   byp_rs1/2    (bypass build only) lookup register indices
//   byp_hit1/2   (bypass build only) lookup hit
//   byp_data1/2  (bypass build only) forwarded data
//
// Optional feature: define REGFILE_WB_BYPASS_EN to add the bypass lookup ports.
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  regfile_wb_if.slave       wb
`ifdef REGFILE_WB_BYPASS_EN
  ,
  input  logic [4:0]        byp_rs1,
  input  logic [4:0]        byp_rs2,
  output logic              byp_hit1,
  output logic              byp_hit2,
  output logic [DATA_W-1:0] byp_data1,
  output logic [DATA_W-1:0] byp_data2
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // FIFO storage; live bits are only ever set on occupied slots
  logic [DEPTH-1:0]  live_r;
  logic [4:0]        rd_r   [DEPTH];
  logic [DATA_W-1:0] data_r [DEPTH];
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [CNT_W-1:0]  count_r;

  // Output stage
  logic              reg_write_r;
  logic [4:0]        w_reg_r;
  logic [DATA_W-1:0] w_data_r;

  logic              alu_req_s;
  logic              mem_ready_s;
  logic              push_s;
  logic              pop_s;
  logic              push_live_s;
  logic [31:0]       pend_s;

  // Request decode, handshake and arbitration decisions
  always_comb begin
    alu_req_s   = wb.alu_valid && (wb.alu_rd != 5'd0);
    // Ready depends on occupancy only: a full FIFO refuses even if it pops now
    mem_ready_s = !reset && (count_r < CNT_W'(DEPTH));
    push_s      = wb.mem_valid && mem_ready_s && (wb.mem_rd != 5'd0);
    // The head is only poppable when the ALU leaves the write port free
    pop_s       = !alu_req_s && (count_r != {CNT_W{1'b0}});
    // A same-cycle ALU write to the same register makes the pushed value stale
    push_live_s = !(alu_req_s && (wb.mem_rd == wb.alu_rd));
  end

  // Live-bit maintenance: reset clear, ALU kill, pop release, push install
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live_r <= {DEPTH{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alu_req_s && (rd_r[i] == wb.alu_rd)) begin
          live_r[i] <= 1'b0;
        end
      end
      if (pop_s) begin
        live_r[head_r] <= 1'b0;
      end
      // The pushed slot is free, so this overrides any kill aimed at stale rd
      if (push_s) begin
        live_r[tail_r] <= push_live_s;
      end
    end
  end

  // FIFO payload write; contents of free slots are don't-care
  always_ff @(posedge clk) begin
    if (push_s) begin
      rd_r[tail_r]   <= wb.mem_rd;
      data_r[tail_r] <= wb.mem_data;
    end
  end

  // Pointers and occupancy; power-of-two DEPTH lets pointers wrap naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        tail_r <= tail_r + PTR_W'(1);
      end
      if (pop_s) begin
        head_r <= head_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Output stage: ALU first, then FIFO head (killed head gives a bubble)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_r <= 1'b0;
      w_reg_r     <= 5'd0;
      w_data_r    <= {DATA_W{1'b0}};
    end else if (alu_req_s) begin
      reg_write_r <= 1'b1;
      w_reg_r     <= wb.alu_rd;
      w_data_r    <= wb.alu_data;
    end else if (pop_s) begin
      reg_write_r <= live_r[head_r];
      w_reg_r     <= rd_r[head_r];
      w_data_r    <= data_r[head_r];
    end else begin
      reg_write_r <= 1'b0;
    end
  end

  // Pending-register mask over live entries
  always_comb begin
    pend_s = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_s = pend_s | ({31'd0, live_r[i]} << rd_r[i]);
    end
  end

  assign wb.mem_ready  = mem_ready_s;
  assign wb.reg_write  = reg_write_r;
  assign wb.w_reg      = w_reg_r;
  assign wb.w_data     = w_data_r;
  assign wb.pend_mask  = pend_s;
  assign wb.fifo_count = count_r;

`ifdef REGFILE_WB_BYPASS_EN
  logic              hit1_s;
  logic              hit2_s;
  logic [DATA_W-1:0] data1_s;
  logic [DATA_W-1:0] data2_s;

  // Bypass lookup: output stage beats the youngest live FIFO match
  always_comb begin
    hit1_s  = 1'b0;
    hit2_s  = 1'b0;
    data1_s = {DATA_W{1'b0}};
    data2_s = {DATA_W{1'b0}};
    // Walk oldest to youngest so the youngest match is the one left standing
    for (int k = 0; k < DEPTH; k++) begin
      if (live_r[head_r + PTR_W'(k)] && (rd_r[head_r + PTR_W'(k)] == byp_rs1)) begin
        hit1_s  = 1'b1;
        data1_s = data_r[head_r + PTR_W'(k)];
      end else begin
        hit1_s  = hit1_s;
      end
      if (live_r[head_r + PTR_W'(k)] && (rd_r[head_r + PTR_W'(k)] == byp_rs2)) begin
        hit2_s  = 1'b1;
        data2_s = data_r[head_r + PTR_W'(k)];
      end else begin
        hit2_s  = hit2_s;
      end
    end
    if (reg_write_r && (w_reg_r == byp_rs1)) begin
      hit1_s  = 1'b1;
      data1_s = w_data_r;
    end else begin
      hit1_s  = hit1_s;
    end
    if (reg_write_r && (w_reg_r == byp_rs2)) begin
      hit2_s  = 1'b1;
      data2_s = w_data_r;
    end else begin
      hit2_s  = hit2_s;
    end
    // x0 never forwards
    if (byp_rs1 == 5'd0) begin
      hit1_s  = 1'b0;
      data1_s = {DATA_W{1'b0}};
    end else begin
      hit1_s  = hit1_s;
    end
    if (byp_rs2 == 5'd0) begin
      hit2_s  = 1'b0;
      data2_s = {DATA_W{1'b0}};
    end else begin
      hit2_s  = hit2_s;
    end
  end

  assign byp_hit1  = hit1_s;
  assign byp_hit2  = hit2_s;
  assign byp_data1 = data1_s;
  assign byp_data2 = data2_s;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Self-checking bench for regfile_wb_arbiter. A queue-based reference model
// steps on each rising edge; every falling edge compares all DUT outputs with
// it. Directed scenarios add literal expectations, then a randomized phase
// with varying ALU load exercises kills, back-pressure and x0 drops.
// Define REGFILE_WB_BYPASS_EN to also check the bypass ports.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) wb ();

  logic [4:0]        byp_rs1;
  logic [4:0]        byp_rs2;
`ifdef REGFILE_WB_BYPASS_EN
  logic              byp_hit1;
  logic              byp_hit2;
  logic [DATA_W-1:0] byp_data1;
  logic [DATA_W-1:0] byp_data2;
`endif

  regfile_wb_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .wb        (wb)
`ifdef REGFILE_WB_BYPASS_EN
    ,
    .byp_rs1   (byp_rs1),
    .byp_rs2   (byp_rs2),
    .byp_hit1  (byp_hit1),
    .byp_hit2  (byp_hit2),
    .byp_data1 (byp_data1),
    .byp_data2 (byp_data2)
`endif
  );

  typedef struct {
    logic              live;
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t              q[$];
  logic              m_rw;
  logic [4:0]        m_wreg;
  logic [DATA_W-1:0] m_wdata;

  int n_chk;
  int n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one register-file write slot, queue of buffered writes
  task automatic model_update();
    bit   alu_req;
    bit   push;
    ent_t e;
    if (reset) begin
      q.delete();
      m_rw    = 1'b0;
      m_wreg  = 5'd0;
      m_wdata = '0;
      return;
    end
    alu_req = wb.alu_valid && (wb.alu_rd != 5'd0);
    push    = wb.mem_valid && (q.size() < DEPTH) && (wb.mem_rd != 5'd0);
    if (alu_req) begin
      foreach (q[i]) if (q[i].rd == wb.alu_rd) q[i].live = 1'b0;
      m_rw    = 1'b1;
      m_wreg  = wb.alu_rd;
      m_wdata = wb.alu_data;
    end else if (q.size() > 0) begin
      e       = q.pop_front();
      m_rw    = e.live;
      m_wreg  = e.rd;
      m_wdata = e.data;
    end else begin
      m_rw = 1'b0;
    end
    if (push) begin
      e.live = !(alu_req && (wb.mem_rd == wb.alu_rd));
      e.rd   = wb.mem_rd;
      e.data = wb.mem_data;
      q.push_back(e);
    end
  endtask

  function automatic logic [31:0] model_pend();
    logic [31:0] m;
    m = 32'd0;
    foreach (q[i]) if (q[i].live) m[q[i].rd] = 1'b1;
    return m;
  endfunction

  // Returns {hit, data}; output stage first, then youngest live entry
  function automatic logic [DATA_W:0] model_byp(input logic [4:0] rs);
    if (rs == 5'd0) return '0;
    if (m_rw && (m_wreg == rs)) return {1'b1, m_wdata};
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].live && (q[i].rd == rs)) return {1'b1, q[i].data};
    end
    return '0;
  endfunction

  task automatic compare_all();
    chk("reg_write",  64'(wb.reg_write),  64'(m_rw));
    chk("w_reg",      64'(wb.w_reg),      64'(m_wreg));
    chk("w_data",     wb.w_data,          m_wdata);
    chk("fifo_count", 64'(wb.fifo_count), 64'(q.size()));
    chk("pend_mask",  64'(wb.pend_mask),  64'(model_pend()));
    chk("mem_ready",  64'(wb.mem_ready),  64'(!reset && (q.size() < DEPTH)));
`ifdef REGFILE_WB_BYPASS_EN
    begin
      logic [DATA_W:0] b1;
      logic [DATA_W:0] b2;
      b1 = model_byp(byp_rs1);
      b2 = model_byp(byp_rs2);
      chk("byp_hit1",  64'(byp_hit1), 64'(b1[DATA_W]));
      chk("byp_data1", byp_data1,     b1[DATA_W-1:0]);
      chk("byp_hit2",  64'(byp_hit2), 64'(b2[DATA_W]));
      chk("byp_data2", byp_data2,     b2[DATA_W-1:0]);
    end
`endif
  endtask

  // One clock: model steps on the rising edge, outputs compared on the falling
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [63:0] md);
    wb.alu_valid = av;
    wb.alu_rd    = ard;
    wb.alu_data  = ad;
    wb.mem_valid = mv;
    wb.mem_rd    = mrd;
    wb.mem_data  = md;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
  endtask

  task automatic mid_reset();
    reset = 1'b1;
    #1;
    model_update();
    compare_all();
    chk("rst_reg_write",  64'(wb.reg_write),  64'd0);
    chk("rst_fifo_count", 64'(wb.fifo_count), 64'd0);
    chk("rst_pend_mask",  64'(wb.pend_mask),  64'd0);
    chk("rst_w_data",     wb.w_data,          64'd0);
    chk("rst_mem_ready",  64'(wb.mem_ready),  64'd0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int alu_pct;
    n_chk   = 0;
    n_fail  = 0;
    m_rw    = 1'b0;
    m_wreg  = 5'd0;
    m_wdata = '0;
    byp_rs1 = 5'd0;
    byp_rs2 = 5'd0;
    reset   = 1'b1;
    idle();
    tick();
    chk("reset_reg_write", 64'(wb.reg_write), 64'd0);
    chk("reset_mem_ready", 64'(wb.mem_ready), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_reset_ready", 64'(wb.mem_ready),  64'd1);
    chk("post_reset_count", 64'(wb.fifo_count), 64'd0);

    // ALU single write: visible one cycle later, gone the cycle after
    drive(1'b1, 5'd5, 64'hAA, 1'b0, 5'd0, 64'd0);
    tick();
    chk("alu_rw",    64'(wb.reg_write), 64'd1);
    chk("alu_wreg",  64'(wb.w_reg),     64'd5);
    chk("alu_wdata", wb.w_data,         64'hAA);
    idle();
    tick();
    chk("alu_rw_drop", 64'(wb.reg_write), 64'd0);

    // Fill FIFO under ALU traffic, then drain in order
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 5'd20, 64'(i + 100), 1'b1, 5'(i), 64'(i * 16));
      tick();
    end
    chk("full_ready", 64'(wb.mem_ready),  64'd0);
    chk("full_count", 64'(wb.fifo_count), 64'd4);
    chk("full_pend",  64'(wb.pend_mask),  64'h1E);
    idle();
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("drain_rw",    64'(wb.reg_write), 64'd1);
      chk("drain_wreg",  64'(wb.w_reg),     64'(i));
      chk("drain_wdata", wb.w_data,         64'(i * 16));
    end
    tick();
    chk("drain_empty", 64'(wb.fifo_count), 64'd0);

    // Later ALU write kills buffered write to same register
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'd1);
    tick();
    chk("kill_pend_set", 64'(wb.pend_mask), 64'h80);
    drive(1'b1, 5'd7, 64'd2, 1'b0, 5'd0, 64'd0);
    tick();
    chk("kill_wdata", wb.w_data,           64'd2);
    chk("kill_pend",  64'(wb.pend_mask),  64'd0);
    chk("kill_count", 64'(wb.fifo_count), 64'd1);
    idle();
    tick();
    chk("kill_bubble", 64'(wb.reg_write),  64'd0);
    chk("kill_popped", 64'(wb.fifo_count), 64'd0);

    // Same-cycle ALU and slow write to one register: push is born dead
    drive(1'b1, 5'd3, 64'h33, 1'b1, 5'd3, 64'h44);
    tick();
    chk("same_wdata", wb.w_data,           64'h33);
    chk("same_count", 64'(wb.fifo_count), 64'd1);
    chk("same_pend",  64'(wb.pend_mask),  64'd0);
    idle();
    tick();
    chk("same_bubble", 64'(wb.reg_write), 64'd0);

    // x0 requests: handshake offered, nothing written or buffered
    drive(1'b1, 5'd0, 64'h55, 1'b1, 5'd0, 64'h66);
    chk("x0_ready", 64'(wb.mem_ready), 64'd1);
    tick();
    chk("x0_rw",    64'(wb.reg_write),  64'd0);
    chk("x0_count", 64'(wb.fifo_count), 64'd0);

    // Two live entries to rd 9 held behind ALU traffic, then reset mid-stream
    drive(1'b1, 5'd20, 64'hA0, 1'b1, 5'd9, 64'h11);
    tick();
    drive(1'b1, 5'd21, 64'hA1, 1'b1, 5'd9, 64'h22);
    byp_rs1 = 5'd9;
    byp_rs2 = 5'd21;
    tick();
    chk("two9_pend", 64'(wb.pend_mask), 64'h200);
`ifdef REGFILE_WB_BYPASS_EN
    chk("byp1_hit",  64'(byp_hit1), 64'd1);
    chk("byp1_data", byp_data1,     64'h22);
    chk("byp2_hit",  64'(byp_hit2), 64'd1);
    chk("byp2_data", byp_data2,     64'hA1);
`endif
    drive(1'b1, 5'd22, 64'hA2, 1'b0, 5'd0, 64'd0);
    mid_reset();
    idle();
    tick();

    // Randomized traffic with varying ALU load to exercise back-pressure
    for (int c = 0; c < 3000; c++) begin
      case ((c / 150) % 3)
        0:       alu_pct = 90;
        1:       alu_pct = 50;
        default: alu_pct = 10;
      endcase
      drive(($urandom_range(99) < alu_pct),
            ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(7)),
            {$urandom, $urandom},
            ($urandom_range(99) < 70),
            ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(7)),
            {$urandom, $urandom});
      byp_rs1 = 5'($urandom_range(7));
      byp_rs2 = 5'($urandom_range(31));
      if (c == 1700) begin
        mid_reset();
      end else begin
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
